// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one shared full-adder cell processes one operand bit per
// clock, LSB first. An addition takes WIDTH RUN cycles followed by a single
// DONE cycle that pulses done. The sum, carry-out and signed overflow then
// hold until the next accepted start.
module bit_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             ovf_q;

  logic [1:0]       fa_out;
  logic             last_bit;

  // The single time-shared cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    full_add = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  assign fa_out   = full_add(a_q[cnt_q], b_q[cnt_q], carry_q);
  assign last_bit = (cnt_q == LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and status outputs; start only matters in IDLE.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, serial sum/carry update and final flag capture.
  // The counter holds at the last index instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= src1;
            b_q      <= src2;
            carry_q  <= cin;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
          end
        end
        RUN: begin
          result_q[cnt_q] <= fa_out[0];
          carry_q         <= fa_out[1];
          if (last_bit) begin
            // carry_q here is the carry into the MSB.
            cout_q <= fa_out[1];
            ovf_q  <= carry_q ^ fa_out[1];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Bench for bit_serial_adder at WIDTH=8: directed vector table, hand-written
// start-held / mid-run reset sequences, then random operands.
module tb_bit_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int checks;
  int errors;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .src1     (src1),
    .src2     (src2),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] exp_r;
    logic         exp_c;
    logic         exp_v;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one addition and wait for done. lat counts edges from the accepting
  // edge (inclusive) to the edge after which done is seen; bcnt counts busy
  // cycles. Operand inputs are scrambled right after acceptance. Outputs are
  // captured while done is high, then one more edge returns the DUT to IDLE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        output int lat, output int bcnt, output bit tmo,
                        output logic [W-1:0] r, output logic c, output logic v);
    @(negedge clk);
    src1 = a; src2 = b; cin = ci; start = 1'b1;
    bcnt = 0; tmo = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    src1 = ~a; src2 = ~b; cin = ~ci;
    lat = 1;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (!done) tmo = 1'b1;
    r = result; c = cout; v = overflow;
    @(posedge clk); #1;
  endtask

  vec_t         vecs[9];
  int           lat;
  int           bcnt;
  bit           tmo;
  logic [W-1:0] r;
  logic         c;
  logic         v;
  int           npulse;
  logic [W:0]   full;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic         rc;
  logic         ev;

  initial begin
    checks = 0; errors = 0;
    start = 1'b0; src1 = '0; src2 = '0; cin = 1'b0;
    rst_n = 1'b0;

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
    vecs[7] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};

    // Reset state, including start asserted while reset is low.
    repeat (2) @(posedge clk);
    start = 1'b1; src1 = 8'h55; src2 = 8'h66;
    @(posedge clk); #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    chk("reset_cout", cout, 0);
    chk("reset_ovf", overflow, 0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset_busy", busy, 0);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].ci, lat, bcnt, tmo, r, c, v);
      chk($sformatf("vec%0d_timeout", i), tmo, 0);
      chk($sformatf("vec%0d_result", i), r, vecs[i].exp_r);
      chk($sformatf("vec%0d_cout", i), c, vecs[i].exp_c);
      chk($sformatf("vec%0d_ovf", i), v, vecs[i].exp_v);
      chk($sformatf("vec%0d_latency", i), lat, W + 1);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, W);
      // Back in IDLE: outputs held, no status.
      chk($sformatf("vec%0d_hold_result", i), result, vecs[i].exp_r);
      chk($sformatf("vec%0d_hold_cout", i), cout, vecs[i].exp_c);
      chk($sformatf("vec%0d_idle_done", i), done, 0);
    end

    // start held high, src1 changed mid-run.
    @(negedge clk);
    src1 = 8'h12; src2 = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;            // accepting edge E0
    npulse = 0;
    for (int e = 1; e <= 9; e++) begin
      if (e == 4) src1 = 8'hFF;
      @(posedge clk); #1;
      if (done) begin
        npulse++;
        chk("held_result", result, 8'h46);
        chk("held_cout", cout, 0);
      end
    end
    chk("held_done_pulses", npulse, 1);
    chk("held_idle_after_done", busy, 0);
    @(posedge clk); #1;            // first IDLE edge accepts again
    chk("held_reaccept_busy", busy, 1);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("held_second_timeout", done, 1);
    chk("held_second_result", result, 8'h33);   // 0xFF + 0x34
    chk("held_second_cout", cout, 1);
    @(posedge clk); #1;

    // Reset pulsed in the middle of RUN.
    @(negedge clk);
    src1 = 8'hAA; src2 = 8'h55; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("midrun_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_busy", busy, 0);
    chk("midrun_reset_done", done, 0);
    chk("midrun_reset_result", result, 0);
    chk("midrun_reset_cout", cout, 0);
    chk("midrun_reset_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    npulse = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (done || busy) npulse++;
    end
    chk("midrun_no_done", npulse, 0);
    run_op(8'h0F, 8'h01, 1'b0, lat, bcnt, tmo, r, c, v);
    chk("after_reset_timeout", tmo, 0);
    chk("after_reset_result", r, 8'h10);
    chk("after_reset_latency", lat, W + 1);

    // Random operands against the reference sum.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      ev = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
      run_op(ra, rb, rc, lat, bcnt, tmo, r, c, v);
      chk("rand_timeout", tmo, 0);
      chk("rand_result", r, full[W-1:0]);
      chk("rand_cout", c, full[W]);
      chk("rand_ovf", v, ev);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
